// File: rtl/hack_pc_if.sv
// Bundle between the Hack CPU core and its program counter:
// control/ALU flags and jump target in, fetch address and status out.
interface hack_pc_if #(
  parameter int WIDTH = 15
);
  logic             soft_reset;
  logic             stall;
  logic             jump_en;
  logic [2:0]       j;
  logic             zr;
  logic             ng;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc;
  logic             jumped;
  logic             halted;

  // Core side: drives control and flags, observes the fetch address.
  modport master (
    output soft_reset, stall, jump_en, j, zr, ng, target,
    input  pc, jumped, halted
  );

  // Program-counter side.
  modport slave (
    input  soft_reset, stall, jump_en, j, zr, ng, target,
    output pc, jumped, halted
  );
endinterface

// File: rtl/hack_pc.sv
// Hack program counter with conditional jumps, stall, soft reset and
// optional detection of the "jump to self" idiom used to end programs.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal fetch: soft_reset > stall > taken jump > increment
// HALT  | jump-to-self seen; pc frozen until soft_reset or nrst
module hack_pc #(
  parameter int WIDTH       = 15,
  parameter bit HALT_DETECT = 1'b1
) (
  input logic   clk,
  input logic   nrst,
  hack_pc_if.slave bus
);

  // The state register doubles as the halted output.
  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pc_q;
  logic             jumped_q;
  logic             take;
  logic             self_jump;
  logic [WIDTH-1:0] pc_inc;

  // Jump condition: j = {lt, eq, gt} matched against the ALU result sign/zero.
  assign take = bus.jump_en & ((bus.j[2] & bus.ng) |
                               (bus.j[1] & bus.zr) |
                               (bus.j[0] & ~bus.ng & ~bus.zr));

  assign self_jump = HALT_DETECT && (bus.target == pc_q);
  assign pc_inc    = pc_q + WIDTH'(1);

  // PC update and RUN/HALT control; all outputs come straight from flops.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc_q     <= '0;
      jumped_q <= 1'b0;
      state_q  <= RUN;
    end else if (bus.soft_reset) begin
      pc_q     <= '0;
      jumped_q <= 1'b0;
      state_q  <= RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.stall) begin
            // hold everything; a self-jump while stalled is not a halt
          end else if (take) begin
            pc_q     <= bus.target;
            jumped_q <= 1'b1;
            if (self_jump) state_q <= HALT;
          end else begin
            pc_q     <= pc_inc;
            jumped_q <= 1'b0;
          end
        end
        HALT: begin
          jumped_q <= 1'b0;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign bus.pc     = pc_q;
  assign bus.jumped = jumped_q;
  assign bus.halted = (state_q == HALT);

endmodule

// File: doc/hack_pc.md
HACK_PC -- requirements
Module: hack_pc

Interface
REQ-001 Parameter: WIDTH, 15, program counter / instruction-ROM address width in bits.
REQ-002 Parameter: HALT_DETECT, 1, enables tight-loop halt detection when 1; when 0, HALT is never entered.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: nrst  input  1  asynchronous, active-low reset.
REQ-005 Port: soft_reset  input  1  synchronous Hack "reset" button, active-high.
REQ-006 Port: stall  input  1  hold PC this cycle.
REQ-007 Port: jump_en  input  1  current instruction is a C-instruction whose jump field is valid.
REQ-008 Port: j  input  3  jump bits {j1,j2,j3} = {lt,eq,gt}.
REQ-009 Port: zr  input  1  ALU result is zero.
REQ-010 Port: ng  input  1  ALU result is negative.
REQ-011 Port: target  input  WIDTH  jump destination, taken from the A register.
REQ-012 Port: pc  output  WIDTH  registered address of the instruction being fetched.
REQ-013 Port: jumped  output  1  registered; 1 when the last PC update was a taken jump.
REQ-014 Port: halted  output  1  registered; 1 while in state HALT.

Function
REQ-015 take = jump_en & ((j[2]&ng) | (j[1]&zr) | (j[0]&~ng&~zr)); j=000 never jumps; j=111 always jumps.
REQ-016 States: RUN, HALT; the state is encoded in the halted register.
REQ-017 Update priority in RUN, per clock edge: soft_reset, then stall, then take, then increment.
REQ-018 soft_reset=1: pc<=0, jumped<=0, state<=RUN; this applies in any state.
REQ-019 stall=1 (no soft_reset): pc, jumped and state hold.
REQ-020 take=1 (no soft_reset, no stall): pc<=target, jumped<=1.
REQ-021 Otherwise: pc<=pc+1 modulo 2^WIDTH, jumped<=0; all-ones wraps to 0 with no flag.
REQ-022 RUN->HALT when HALT_DETECT=1, take=1, target==pc, and soft_reset=0 and stall=0 in that cycle; pc<=target on that edge.
REQ-023 HALT: pc holds; take, stall and increment are ignored; jumped<=0; halted=1.
REQ-024 HALT->RUN only via soft_reset (pc<=0) or nrst.
REQ-025 A taken jump with target!=pc never enters HALT.
REQ-026 A jump to the current pc while stalled is not a halt.
REQ-027 No combinational path from any input to any output.

Reset
REQ-028 While nrst=0, asynchronously: pc=0, jumped=0, halted=0, state=RUN.
REQ-029 Deassertion of nrst takes effect at the next rising edge, with normal REQ-017 priority.
REQ-030 nrst asserted mid-jump or in HALT overrides everything immediately.

Verification
REQ-031 Reset, then 5 idle edges -> pc=0,1,2,3,4,5; jumped=0; halted=0.
REQ-032 pc=0x0010, jump_en=1, j=001, zr=0, ng=0, target=0x0100 -> next pc=0x0100, jumped=1. Repeat with ng=1 -> pc=0x0011, jumped=0.
REQ-033 pc=0x7FFF, no jump -> pc=0x0000, halted=0.
REQ-034 pc=0x0020, stall=1 with take=1 and target=0x0040 -> pc=0x0020 held. Repeat with soft_reset=1 also set -> pc=0.
REQ-035 pc=0x0005, j=111, target=0x0005 -> halted=1, pc=0x0005 held for 10 edges despite further jumps to 0x0100. Then soft_reset -> pc=0, halted=0.
REQ-036 Drop nrst asynchronously mid-cycle in HALT with pc=0x1234 -> pc=0 and halted=0 immediately, without a clock edge.
